// File: rtl/exec_controller.sv
// exec_controller -- run/step/halt sequencer for the 8-bit single-cycle datapath.
//
// Fetches one instruction at a time from a synchronous instruction memory
// addressed by the datapath PC, registers it onto instr, and pulses cpu_en for
// exactly one cycle so the datapath commits that instruction. Supports
// free-run, single-step, breakpoint, end-address stop and a retired counter.
//
// Ports
//   CLK, RESET          clock (rising edge), async active-low reset
//   run, step, halt     control: run level, step rising edge, halt level (top priority)
//   bp_en, bp_addr      breakpoint enable / PC
//   pc                  current PC from datapath
//   imem_rdata          instruction memory data, valid one cycle after imem_addr
//   imem_addr           = pc
//   instr, cpu_en       registered instruction and one-cycle commit enable
//   state               FSM state code (IDLE=0 FETCH=1 DECODE=2 EXEC=3 PAUSE=4)
//   bp_hit, done        sticky breakpoint / end-of-program flags
//   retired             instructions issued since reset (wraps)
module exec_controller #(
  parameter int                DATA_W   = 8,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] END_ADDR = {DATA_W{1'b1}}
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              run,
  input  logic              step,
  input  logic              halt,
  input  logic              bp_en,
  input  logic [DATA_W-1:0] bp_addr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] imem_addr,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic              bp_hit,
  output logic              done,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    PAUSE  = 3'd4
  } state_e;

  state_e state_q;
  logic   step_q;
  logic   one_shot;  // current instruction was started by a step edge
  logic   bp_skip;   // lets the instruction at the breakpoint issue on resume
  logic   step_edge;

  assign imem_addr = pc;
  assign state     = state_q;
  assign step_edge = step & ~step_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      instr    <= '0;
      cpu_en   <= 1'b0;
      bp_hit   <= 1'b0;
      bp_skip  <= 1'b0;
      done     <= 1'b0;
      retired  <= '0;
      step_q   <= 1'b0;
      one_shot <= 1'b0;
    end else begin
      step_q <= step;
      cpu_en <= 1'b0;
      case (state_q)
        IDLE, PAUSE: begin
          if (halt) begin
            state_q  <= IDLE;
            one_shot <= 1'b0;
          end else if (!(state_q == IDLE && done)) begin
            // run takes precedence, so a step edge together with run acts as run
            if (run) begin
              state_q  <= FETCH;
              one_shot <= 1'b0;
            end else if (step_edge) begin
              state_q  <= FETCH;
              one_shot <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (halt) begin
            state_q <= IDLE;
          end else if (pc == END_ADDR) begin
            state_q <= IDLE;
            done    <= 1'b1;
          end else if (bp_en && pc == bp_addr && !bp_skip) begin
            state_q <= PAUSE;
            bp_hit  <= 1'b1;
            bp_skip <= 1'b1;
          end else begin
            state_q <= DECODE;
          end
        end
        DECODE: begin
          // memory data for pc is valid now; load it even if halted
          instr <= imem_rdata;
          if (halt) begin
            state_q <= IDLE;
          end else begin
            state_q <= EXEC;
            cpu_en  <= 1'b1;
          end
        end
        EXEC: begin
          retired  <= retired + CNT_W'(1);
          bp_hit   <= 1'b0;
          bp_skip  <= 1'b0;
          one_shot <= 1'b0;
          if (halt)                 state_q <= IDLE;
          else if (one_shot || !run) state_q <= PAUSE;
          else                      state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
